count_display: RTL and testbench

Two-digit multiplexed seven-segment driver for the 5-bit lab counter value. It sits directly downstream of the counter: it takes the 0–31 count, splits it into tens and ones BCD digits, and time-multiplexes them onto a common-anode display. The input is latched once per refresh frame, so a digit pair never mixes two different counts.

---
 rtl/count_display_pkg.sv | 36 +++
 rtl/count_display_seg7_decode.sv | 30 +++
 rtl/count_display.sv | 115 +++++++++++
 tb/tb_count_display.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared constants for the two-digit seven-segment driver.
// Segment bit order for every pattern below: bit 6..0 = {g,f,e,d,c,b,a}.
// All segment and anode levels are active-low (0 = lit / driven).
package count_display_pkg;

  // Digit glyphs, active-low gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode select patterns, active-low; an[0] = ones, an[1] = tens
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;

  // Which digit is currently being driven
  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_t;

  // Multiples of ten that the tens digit stands for
  localparam logic [4:0] TENS_0_X10 = 5'd0;
  localparam logic [4:0] TENS_1_X10 = 5'd10;
  localparam logic [4:0] TENS_2_X10 = 5'd20;
  localparam logic [4:0] TENS_3_X10 = 5'd30;

endpackage

// File: rtl/count_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment glyph decoder.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pick the glyph; blank wins, and non-decimal codes (never produced upstream) show nothing
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display.sv
// Two-digit multiplexed seven-segment driver for a 0..31 count.
// The count is captured once per refresh frame (ones slot then tens slot),
// so the two digits shown always belong to the same sampled value.
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] value_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  // A one-cycle slot still needs a one-bit prescaler so the logic stays uniform
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt;
  slot_t         slot;
  logic [4:0]    shadow;

  logic          slot_end;
  logic          latch_now;
  logic [1:0]    tens;
  logic [4:0]    tens_x10;
  logic [3:0]    ones;
  logic [3:0]    digit;
  logic          digit_blank;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  assign slot_end  = (pcnt == PCNT_MAX);
  assign latch_now = slot_end && (slot == SLOT_TENS);

  // The decimal point is never used on this display
  assign dp = 1'b1;

  // Prescaler and slot toggle: each slot lasts REFRESH_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      slot <= SLOT_ONES;
    end else if (slot_end) begin
      pcnt <= '0;
      slot <= (slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Capture the count only at the tens-to-ones boundary so a frame never mixes two values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= latch_now;
      if (latch_now) begin
        shadow <= value_in;
      end
    end
  end

  // Split the captured count into tens/ones with range compares instead of a divider
  always_comb begin
    tens     = 2'd0;
    tens_x10 = TENS_0_X10;
    if (shadow >= 5'd30) begin
      tens     = 2'd3;
      tens_x10 = TENS_3_X10;
    end else if (shadow >= 5'd20) begin
      tens     = 2'd2;
      tens_x10 = TENS_2_X10;
    end else if (shadow >= 5'd10) begin
      tens     = 2'd1;
      tens_x10 = TENS_1_X10;
    end
    ones = 4'(shadow - tens_x10);
  end

  // Choose the digit and anode for the slot being shown, with optional leading-zero blanking
  always_comb begin
    digit       = ones;
    digit_blank = 1'b0;
    an_next     = AN_ONES;
    if (slot == SLOT_TENS) begin
      digit       = {2'b00, tens};
      digit_blank = LZ_BLANK && (tens == 2'd0);
      an_next     = AN_TENS;
    end
  end

  seg7_decode u_decode (
    .digit (digit),
    .blank (digit_blank),
    .seg   (seg_next)
  );

  // Register the display drive so outputs are glitch-free and follow slot/shadow by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench: three display instances (slow refresh with and without
// leading-zero blanking, and the fastest refresh) compared cycle by cycle
// against a frame-level reference model.
module tb_count_display;

  logic       clk;
  logic       rst;
  logic [4:0] value_in;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b, an_c;
  logic       ft_a, ft_b, ft_c;

  int checks;
  int passes;
  int fails;

  // Reference model state: edges since reset and displayed value per refresh rate
  int         edges4;
  int         edges1;
  logic [4:0] shown4;
  logic [4:0] shown1;
  logic       exp_ft4;
  logic       exp_ft1;
  logic [3:0] exp_an_a, exp_an_c;
  logic [6:0] exp_seg_a, exp_seg_b, exp_seg_c;

  logic [6:0] glyph [10];
  logic [6:0] glyph_blank;

  count_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .value_in(value_in),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
  );

  count_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .value_in(value_in),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b)
  );

  count_display #(.REFRESH_DIV(1), .LZ_BLANK(1'b1)) dut_c (
    .clk(clk), .rst(rst), .value_in(value_in),
    .seg(seg_c), .dp(dp_c), .an(an_c), .frame_tick(ft_c)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Expected glyph for a value in a given slot (slot 1 = tens digit)
  function automatic logic [6:0] expectGlyph(input logic [4:0] v, input int slot, input bit lz);
    int t, o;
    t = int'(v) / 10;
    o = int'(v) % 10;
    if (slot == 0) return glyph[o];
    if (lz && t == 0) return glyph_blank;
    return glyph[t];
  endfunction

  // Advance the model by one clock edge; expected outputs come from the state before the edge
  task automatic modelEdge();
    int s4, s1;
    s4 = (edges4 / 4) % 2;
    s1 = edges1 % 2;
    exp_an_a  = (s4 == 1) ? 4'b1101 : 4'b1110;
    exp_seg_a = expectGlyph(shown4, s4, 1'b1);
    exp_seg_b = expectGlyph(shown4, s4, 1'b0);
    exp_an_c  = (s1 == 1) ? 4'b1101 : 4'b1110;
    exp_seg_c = expectGlyph(shown1, s1, 1'b1);
    edges4++;
    edges1++;
    exp_ft4 = (edges4 % 8 == 0);
    exp_ft1 = (edges1 % 2 == 0);
    if (exp_ft4) shown4 = value_in;
    if (exp_ft1) shown1 = value_in;
  endtask

  task automatic modelReset();
    edges4 = 0;
    edges1 = 0;
    shown4 = 5'd0;
    shown1 = 5'd0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_an_a"},  7'(an_a),  7'b0001111);
    checkOutput({tag, "_seg_a"}, seg_a,     7'b1111111);
    checkOutput({tag, "_dp_a"},  7'(dp_a),  7'd1);
    checkOutput({tag, "_ft_a"},  7'(ft_a),  7'd0);
    checkOutput({tag, "_an_b"},  7'(an_b),  7'b0001111);
    checkOutput({tag, "_seg_b"}, seg_b,     7'b1111111);
    checkOutput({tag, "_an_c"},  7'(an_c),  7'b0001111);
    checkOutput({tag, "_seg_c"}, seg_c,     7'b1111111);
    checkOutput({tag, "_ft_c"},  7'(ft_c),  7'd0);
  endtask

  // Drive a value for n cycles, checking every output of every instance after each edge
  task automatic applyStimulus(input logic [4:0] v, input int n);
    value_in = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("an_a",  7'(an_a), 7'(exp_an_a));
      checkOutput("seg_a", seg_a,    exp_seg_a);
      checkOutput("ft_a",  7'(ft_a), 7'(exp_ft4));
      checkOutput("an_b",  7'(an_b), 7'(exp_an_a));
      checkOutput("seg_b", seg_b,    exp_seg_b);
      checkOutput("ft_b",  7'(ft_b), 7'(exp_ft4));
      checkOutput("an_c",  7'(an_c), 7'(exp_an_c));
      checkOutput("seg_c", seg_c,    exp_seg_c);
      checkOutput("ft_c",  7'(ft_c), 7'(exp_ft1));
      checkOutput("dp",    7'({dp_a, dp_b, dp_c}), 7'b0000111);
    end
  endtask

  initial begin
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
    glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
    glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
    glyph[9] = 7'b0010000;
    glyph_blank = 7'b1111111;
    checks = 0;
    passes = 0;
    fails  = 0;
    exp_ft4 = 1'b0;
    exp_ft1 = 1'b0;

    // Startup: reset values, then first frame of zero (ones "0", tens blank)
    rst = 1'b1;
    value_in = 5'd0;
    modelReset();
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(5'd0, 8);
    $display("[TB] startup frame done");

    // Steady value 23 over two frames
    applyStimulus(5'd23, 16);

    // Mid-frame change 23 -> 31 early in the ones slot
    applyStimulus(5'd23, 1);
    applyStimulus(5'd31, 3);
    applyStimulus(5'd31, 12);

    // Counter wrap 31 -> 0: tens blanked on one instance, "0" on the other
    applyStimulus(5'd0, 16);
    $display("[TB] directed patterns done");

    // Random values held for random lengths
    for (int k = 0; k < 150; k++) begin
      applyStimulus(5'($urandom_range(0, 31)), $urandom_range(1, 6));
    end

    // Park in the tens slot with 23 captured, then reset asynchronously between edges
    for (int k = 0; k < 8 && (edges4 % 8) != 5; k++) begin
      applyStimulus(5'd23, 1);
    end
    applyStimulus(5'd23, 16);
    checkOutput("pre_reset_an_a", 7'(an_a), 7'b0001101);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("async");
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkResetValues("held");
    rst = 1'b0;
    applyStimulus(5'd5, 16);
    $display("[TB] async reset sequence done");

    // More random traffic, including single-cycle changes
    for (int k = 0; k < 150; k++) begin
      applyStimulus(5'($urandom_range(0, 31)), $urandom_range(1, 3));
    end

    // Fast-refresh scenario value 17
    applyStimulus(5'd17, 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
